sd_spi_host_cmd: RTL and testbench
==================================

Name: sd_spi_host_cmd

Overview:
SPI-mode SD host command engine: the initiator end of the SD-card SPI link that the sd_phy/sd_link emulator answers.
- Frames one SD command: CRC7 computed in hardware, wrapped in CS and fill bytes.
- Clocks it out as an SPI mode-0 master, polls for the response start, captures R1/R2/R3/R7, then releases CS.
- Used as a loopback driver for the emulator and as the command path of a future host-side test harness.

Parameters:
CLK_DIV, 2, half-period of spi_sclk in clk_50 cycles (>=1)
NCR_MAX, 8, max 0xFF fill bytes polled before a response start is declared missing
PRE_FF, 1, 0xFF bytes sent with CS low before the command token

Ports:
clk_50  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_start  in  1  one-cycle request pulse
cmd_index  in  6  command number (0..63)
cmd_arg  in  32  command argument
resp_len  in  3  response bytes: 1 (R1), 2 (R2), 5 (R3/R7)
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
timeout  out  1  valid with done: no response start seen
resp_data  out  40  captured response, right-aligned
spi_sclk  out  1  SPI clock, idle low
spi_mosi  out  1  host data out, idle high
spi_miso  in  1  card data in
spi_cs_n  out  1  chip select, active low

Behaviour:
- Reset values (async, immediate even mid-frame): spi_cs_n=1, spi_sclk=0, spi_mosi=1, busy=0, done=0, timeout=0, resp_data=0, FSM=IDLE, all counters 0.
- SPI mode 0, MSB first:
  - MOSI updates on the sclk falling edge; the first bit is set up one half-period before the first rising edge.
  - MISO is sampled on the rising edge.
  - One bit = 2*CLK_DIV clk_50 cycles; one byte = 16*CLK_DIV cycles.
- cmd_start is accepted only in IDLE; it is ignored while busy.
- On accept, latch cmd_index/cmd_arg/resp_len, clear resp_data and timeout, set busy.
- resp_len normalisation: 0 treated as 1; 3, 4 and >5 treated as 5.
- FSM (every byte is a single handshake to the shifter):
  - IDLE -> CS_LO: drive cs_n=0, wait one half-period.
  - PRE: send PRE_FF bytes of 0xFF.
  - CMD: send 6 bytes, in order:
    - {2'b01, index}
    - arg[31:24], arg[23:16], arg[15:8], arg[7:0]
    - {crc7, 1'b1}
  - WAIT_R: send 0xFF and test the received byte.
    - rx[7]==0: shift it into resp_data, remaining=len-1, go RESP (or TAIL if remaining is 0).
    - Otherwise increment the poll counter; when it reaches NCR_MAX, set timeout=1 and go TAIL.
  - RESP: send 0xFF, shift each rx byte in at the LSB (resp_data <= {resp_data[31:0], rx}) until remaining is 0.
  - TAIL: cs_n=1, send one 0xFF byte (8 release clocks).
  - DONE: pulse done for 1 cycle, clear busy, return to IDLE.
- CRC7:
  - Polynomial x^7+x^3+1, initial value 0.
  - Computed bit-serially over the first 40 frame bits as they are shifted out, one update per bit.
  - Not precomputed; no extra latency.
- Timeout result: resp_data stays 0.
- MISO bytes received during PRE and CMD are discarded.
- Write-data tokens, data-block reads and the busy (R1b) wait are out of scope.

Decomposition:
- Shared package sd_spi_pkg holds:
  - FSM state encoding
  - START_BITS=2'b01, CRC7_POLY=7'h09, FILL_BYTE=8'hFF
  - response-length constants R1=1, R2=2, R7=5
- Sub-module sd_spi_shift owns the clock divider, sclk generation and the 8-bit TX/RX shift registers.
  - Handshake inputs: xfer_go (1-cycle), tx_byte[7:0].
  - Handshake outputs: xfer_done (1-cycle, rx_byte valid), bit_strobe (1-cycle at each MOSI bit launch, used for the CRC update).
  - spi_sclk, spi_mosi and spi_miso connect through this sub-module.
- The top level holds the command FSM, the CRC7 and the response capture.

Test Plan:
1. CMD0, arg 0, resp_len 1; card model returns 0x01 after one fill byte -> MOSI bytes FF 40 00 00 00 00 95 FF FF, then FF after CS high; resp_data=40'h01, timeout=0, single done pulse.
2. CMD8, arg 0x000001AA, resp_len 5; card returns R7 01 00 00 01 AA -> CRC byte 0x87, resp_data=40'h01000001AA, cs_n high only in TAIL.
3. MISO held high, CMD58, resp_len 5 -> exactly NCR_MAX(8) poll bytes, then TAIL; done with timeout=1, resp_data=0; total frame = (1+6+8+1) bytes × 16×CLK_DIV clk_50 cycles.
4. Second cmd_start pulsed mid-frame during CMD -> ignored: one done, frame bytes unchanged.
5. reset_n asserted during WAIT_R -> same cycle cs_n=1, sclk=0, busy=0; after release, a new CMD55 (0x77 00 00 00 00 CRC 0x65) completes normally.
6. resp_len=0 and resp_len=7 -> behave as 1 and 5 respectively (byte counts on MOSI verified).

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SPI-mode SD host command engine: FSM encoding,
// framing constants and the bit-serial CRC7 step.
package sd_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CS_LO,
      ST_PRE,
      ST_CMD,
      ST_WAIT_R,
      ST_RESP,
      ST_TAIL,
      ST_DONE
   } state_t;

   localparam logic [1:0] START_BITS = 2'b01;
   localparam logic [6:0] CRC7_POLY  = 7'h09;
   localparam logic [7:0] FILL_BYTE  = 8'hFF;

   localparam logic [2:0] R1 = 3'd1;
   localparam logic [2:0] R2 = 3'd2;
   localparam logic [2:0] R7 = 3'd5;

   // Anything that is not a 2-byte request is read as the short or long form.
   function automatic logic [2:0] norm_resp_len(input logic [2:0] len);
      case (len)
         3'd0, 3'd1: return R1;
         3'd2:       return R2;
         default:    return R7;
      endcase
   endfunction

   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
      logic fb;
      fb = crc[6] ^ bit_in;
      return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_spi_shift.sv
// SPI mode-0 byte shifter: divides clk_50 into spi_sclk, launches MOSI on the
// falling edge, samples MISO on the rising edge, one byte per xfer_go.
module sd_spi_shift
   import sd_spi_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic       clk_50,
   input  logic       reset_n,
   input  logic       xfer_go,
   input  logic [7:0] tx_byte,
   output logic       xfer_done,
   output logic [7:0] rx_byte,
   output logic       bit_strobe,
   output logic       spi_sclk,
   output logic       spi_mosi,
   input  logic       spi_miso
);

   localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic          active;
   logic [DW-1:0] div_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    tx_sr;
   logic [7:0]    rx_sr;

   // NOTE: all state here is sequential and uses <= so sclk, MOSI and the
   // shift registers move on the same clk_50 edge without ordering races.
   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         active     <= 1'b0;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         tx_sr      <= '0;
         rx_sr      <= '0;
         rx_byte    <= '0;
         xfer_done  <= 1'b0;
         bit_strobe <= 1'b0;
         spi_sclk   <= 1'b0;
         spi_mosi   <= 1'b1;
      end else begin
         xfer_done  <= 1'b0;
         bit_strobe <= 1'b0;
         if (!active) begin
            if (xfer_go) begin
               // First bit goes out now, a full half-period before the first rise.
               active     <= 1'b1;
               div_cnt    <= '0;
               bit_cnt    <= '0;
               tx_sr      <= {tx_byte[6:0], 1'b1};
               spi_mosi   <= tx_byte[7];
               bit_strobe <= 1'b1;
            end
         end else if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
         end else begin
            div_cnt  <= '0;
            spi_sclk <= ~spi_sclk;
            if (!spi_sclk) begin
               rx_sr <= {rx_sr[6:0], spi_miso};
            end else if (bit_cnt == 3'd7) begin
               active    <= 1'b0;
               xfer_done <= 1'b1;
               rx_byte   <= rx_sr;
               spi_mosi  <= FILL_BYTE[7];
            end else begin
               bit_cnt    <= bit_cnt + 1'b1;
               spi_mosi   <= tx_sr[7];
               tx_sr      <= {tx_sr[6:0], 1'b1};
               bit_strobe <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sd_spi_host_cmd.sv
// SPI-mode SD host command engine: frames one command with on-the-fly CRC7,
// polls for the response start, captures up to 5 response bytes.
module sd_spi_host_cmd
   import sd_spi_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int NCR_MAX = 8,
   parameter int PRE_FF  = 1
) (
   input  logic        clk_50,
   input  logic        reset_n,
   input  logic        cmd_start,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   input  logic [2:0]  resp_len,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [39:0] resp_data,
   output logic        spi_sclk,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        spi_cs_n
);

   localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [7:0]    PRE_LAST = 8'(PRE_FF - 1);
   localparam logic [7:0]    NCR_LAST = 8'(NCR_MAX - 1);

   state_t        state;
   logic [5:0]    idx_q;
   logic [31:0]   arg_q;
   logic [2:0]    len_q;
   logic [2:0]    remaining;
   logic [7:0]    byte_cnt;
   logic [7:0]    poll_cnt;
   logic [DW-1:0] half_cnt;
   logic [6:0]    crc;
   logic          wait_xfer;
   logic          xfer_go;
   logic [7:0]    tx_byte;
   logic          xfer_done;
   logic [7:0]    rx_byte;
   logic          bit_strobe;
   logic [7:0]    cmd_tx;

   sd_spi_shift #(.CLK_DIV(CLK_DIV)) u_shift (
      .clk_50     (clk_50),
      .reset_n    (reset_n),
      .xfer_go    (xfer_go),
      .tx_byte    (tx_byte),
      .xfer_done  (xfer_done),
      .rx_byte    (rx_byte),
      .bit_strobe (bit_strobe),
      .spi_sclk   (spi_sclk),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso)
   );

   // NOTE: default assigned first so no path through the case leaves cmd_tx
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      cmd_tx = FILL_BYTE;
      case (byte_cnt)
         8'd0:    cmd_tx = {START_BITS, idx_q};
         8'd1:    cmd_tx = arg_q[31:24];
         8'd2:    cmd_tx = arg_q[23:16];
         8'd3:    cmd_tx = arg_q[15:8];
         8'd4:    cmd_tx = arg_q[7:0];
         8'd5:    cmd_tx = {crc, 1'b1};
         default: cmd_tx = FILL_BYTE;
      endcase
   end

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         idx_q     <= '0;
         arg_q     <= '0;
         len_q     <= '0;
         remaining <= '0;
         byte_cnt  <= '0;
         poll_cnt  <= '0;
         half_cnt  <= '0;
         crc       <= '0;
         wait_xfer <= 1'b0;
         xfer_go   <= 1'b0;
         tx_byte   <= FILL_BYTE;
         busy      <= 1'b0;
         done      <= 1'b0;
         timeout   <= 1'b0;
         resp_data <= '0;
         spi_cs_n  <= 1'b1;
      end else begin
         xfer_go <= 1'b0;
         done    <= 1'b0;
         // CRC follows the first 40 bits as each one is launched on MOSI.
         if (bit_strobe && state == ST_CMD && byte_cnt < 8'd5)
            crc <= crc7_step(crc, spi_mosi);

         case (state)
            ST_IDLE: begin
               if (cmd_start) begin
                  idx_q     <= cmd_index;
                  arg_q     <= cmd_arg;
                  len_q     <= norm_resp_len(resp_len);
                  resp_data <= '0;
                  timeout   <= 1'b0;
                  busy      <= 1'b1;
                  crc       <= '0;
                  byte_cnt  <= '0;
                  poll_cnt  <= '0;
                  half_cnt  <= '0;
                  spi_cs_n  <= 1'b0;
                  state     <= ST_CS_LO;
               end
            end
            ST_CS_LO: begin
               if (half_cnt == DIV_LAST) state <= (PRE_FF > 0) ? ST_PRE : ST_CMD;
               else                      half_cnt <= half_cnt + 1'b1;
            end
            ST_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               if (!wait_xfer) begin
                  xfer_go   <= 1'b1;
                  tx_byte   <= (state == ST_CMD) ? cmd_tx : FILL_BYTE;
                  wait_xfer <= 1'b1;
               end else if (xfer_done) begin
                  wait_xfer <= 1'b0;
                  case (state)
                     ST_PRE: begin
                        if (byte_cnt == PRE_LAST) begin
                           byte_cnt <= '0;
                           state    <= ST_CMD;
                        end else begin
                           byte_cnt <= byte_cnt + 1'b1;
                        end
                     end
                     ST_CMD: begin
                        if (byte_cnt == 8'd5) begin
                           byte_cnt <= '0;
                           state    <= ST_WAIT_R;
                        end else begin
                           byte_cnt <= byte_cnt + 1'b1;
                        end
                     end
                     ST_WAIT_R: begin
                        if (!rx_byte[7]) begin
                           resp_data <= {resp_data[31:0], rx_byte};
                           remaining <= len_q - 3'd1;
                           if (len_q == R1) begin
                              spi_cs_n <= 1'b1;
                              state    <= ST_TAIL;
                           end else begin
                              state <= ST_RESP;
                           end
                        end else if (poll_cnt == NCR_LAST) begin
                           timeout  <= 1'b1;
                           spi_cs_n <= 1'b1;
                           state    <= ST_TAIL;
                        end else begin
                           poll_cnt <= poll_cnt + 1'b1;
                        end
                     end
                     ST_RESP: begin
                        resp_data <= {resp_data[31:0], rx_byte};
                        remaining <= remaining - 3'd1;
                        if (remaining == 3'd1) begin
                           spi_cs_n <= 1'b1;
                           state    <= ST_TAIL;
                        end
                     end
                     ST_TAIL: state <= ST_DONE;
                     default: state <= ST_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_spi_host_cmd.sv
// Scoreboard bench for sd_spi_host_cmd: a card model answers on MISO, monitors
// pop expected MOSI bytes and command results as the DUT produces them.
module tb_sd_spi_host_cmd;

   logic        clk_50 = 1'b0;
   logic        reset_n;
   logic        cmd_start;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic [2:0]  resp_len;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [39:0] resp_data;
   logic        spi_sclk;
   logic        spi_mosi;
   logic        spi_miso;
   logic        spi_cs_n;

   sd_spi_host_cmd #(.CLK_DIV(2), .NCR_MAX(8), .PRE_FF(1)) dut (
      .clk_50    (clk_50),
      .reset_n   (reset_n),
      .cmd_start (cmd_start),
      .cmd_index (cmd_index),
      .cmd_arg   (cmd_arg),
      .resp_len  (resp_len),
      .busy      (busy),
      .done      (done),
      .timeout   (timeout),
      .resp_data (resp_data),
      .spi_sclk  (spi_sclk),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .spi_cs_n  (spi_cs_n)
   );

   always #5 clk_50 = ~clk_50;

   typedef struct {
      logic [7:0] b;
      logic       cs;
   } mosi_t;

   typedef struct {
      logic [39:0] data;
      logic        to;
   } res_t;

   mosi_t exp_mosi[$];
   res_t  exp_res[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Card model: answers with card_resp[] byte by byte from CS falling edge.
   logic [7:0] card_resp [32];
   logic [7:0] card_cur;
   int         card_bits;
   logic       card_sclk_q;
   logic       card_cs_q;

   always @(negedge clk_50) begin
      if (!reset_n) begin
         card_bits   = 0;
         card_sclk_q = 1'b0;
         card_cs_q   = 1'b1;
         spi_miso    = 1'b1;
      end else begin
         if (card_cs_q && !spi_cs_n)        card_bits = 0;
         else if (card_sclk_q && !spi_sclk) card_bits++;
         card_sclk_q = spi_sclk;
         card_cs_q   = spi_cs_n;
         if (spi_cs_n || card_bits >= 256) begin
            spi_miso = 1'b1;
         end else begin
            card_cur = card_resp[card_bits / 8];
            spi_miso = card_cur[7 - (card_bits % 8)];
         end
      end
   end

   // MOSI monitor: assembles bytes on sclk rising edges and scores them.
   int         mon_cnt = 0;
   int         mon_nbytes = 0;
   int         mon_rises = 0;
   logic       mon_sclk_q = 1'b0;
   logic       mon_cs;
   logic [7:0] mon_sr;
   mosi_t      mon_e;

   always @(negedge clk_50) begin
      if (!reset_n) begin
         mon_cnt    = 0;
         mon_sclk_q = 1'b0;
      end else begin
         if (!mon_sclk_q && spi_sclk) begin
            mon_rises++;
            if (mon_cnt == 0) mon_cs = spi_cs_n;
            mon_sr = {mon_sr[6:0], spi_mosi};
            mon_cnt++;
            if (mon_cnt == 8) begin
               mon_cnt = 0;
               mon_nbytes++;
               if (exp_mosi.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL mosi_extra: got byte 0x%0h with cs_n=%0b, none expected", mon_sr, mon_cs);
               end else begin
                  mon_e = exp_mosi.pop_front();
                  check("mosi_byte", 64'(mon_sr), 64'(mon_e.b));
                  check("mosi_cs_n", 64'(mon_cs), 64'(mon_e.cs));
               end
            end
         end
         mon_sclk_q = spi_sclk;
      end
   end

   // Result monitor: scores resp_data/timeout on every done pulse.
   res_t res_e;

   always @(negedge clk_50) begin
      if (reset_n && done) begin
         if (exp_res.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_extra: got done with resp_data=0x%0h, none expected", resp_data);
         end else begin
            res_e = exp_res.pop_front();
            check("resp_data", 64'(resp_data), 64'(res_e.data));
            check("timeout", 64'(timeout), 64'(res_e.to));
         end
      end
   end

   task automatic set_card(input int first, input logic [39:0] r, input int n);
      logic [39:0] tmp;
      for (int i = 0; i < 32; i++) card_resp[i] = 8'hFF;
      tmp = r << (8 * (5 - n));
      for (int i = 0; i < n; i++) begin
         card_resp[first + i] = tmp[39:32];
         tmp = tmp << 8;
      end
   endtask

   task automatic push_byte(input logic [7:0] b, input logic cs);
      mosi_t m;
      m.b  = b;
      m.cs = cs;
      exp_mosi.push_back(m);
   endtask

   task automatic expect_frame(input logic [5:0] idx, input logic [31:0] arg,
                               input logic [7:0] crc_byte, input int n_fill);
      push_byte(8'hFF, 1'b0);
      push_byte({2'b01, idx}, 1'b0);
      push_byte(arg[31:24], 1'b0);
      push_byte(arg[23:16], 1'b0);
      push_byte(arg[15:8], 1'b0);
      push_byte(arg[7:0], 1'b0);
      push_byte(crc_byte, 1'b0);
      for (int i = 0; i < n_fill; i++) push_byte(8'hFF, 1'b0);
      push_byte(8'hFF, 1'b1);
   endtask

   task automatic expect_res(input logic [39:0] data, input logic to);
      res_t r;
      r.data = data;
      r.to   = to;
      exp_res.push_back(r);
   endtask

   task automatic start(input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] len);
      @(negedge clk_50);
      cmd_index = idx;
      cmd_arg   = arg;
      resp_len  = len;
      cmd_start = 1'b1;
      @(negedge clk_50);
      cmd_start = 1'b0;
   endtask

   task automatic wait_done(input string name, output int cycles);
      cycles = 0;
      while ((exp_res.size() != 0 || busy) && cycles < 5000) begin
         @(negedge clk_50);
         cycles++;
      end
      check({name, "_finished"}, 64'(cycles < 5000), 64'd1);
      repeat (20) @(negedge clk_50);
      check({name, "_mosi_left"}, 64'(exp_mosi.size()), 64'd0);
      check({name, "_idle_cs_n"}, 64'(spi_cs_n), 64'd1);
   endtask

   task automatic wait_bytes(input int target);
      int cyc;
      cyc = 0;
      while (mon_nbytes < target && cyc < 5000) begin
         @(negedge clk_50);
         cyc++;
      end
      check("byte_wait_bound", 64'(cyc < 5000), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int rises0;
      int base;

      reset_n   = 1'b0;
      cmd_start = 1'b0;
      cmd_index = '0;
      cmd_arg   = '0;
      resp_len  = '0;
      for (int i = 0; i < 32; i++) card_resp[i] = 8'hFF;

      #12;
      check("rst_cs_n", 64'(spi_cs_n), 64'd1);
      check("rst_sclk", 64'(spi_sclk), 64'd0);
      check("rst_mosi", 64'(spi_mosi), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_timeout", 64'(timeout), 64'd0);
      check("rst_resp_data", 64'(resp_data), 64'd0);
      @(negedge clk_50);
      reset_n = 1'b1;
      repeat (3) @(negedge clk_50);

      // 1: CMD0, R1 answered after one fill byte
      set_card(8, 40'h01, 1);
      expect_frame(6'd0, 32'h0, 8'h95, 2);
      expect_res(40'h01, 1'b0);
      start(6'd0, 32'h0, 3'd1);
      check("t1_busy", 64'(busy), 64'd1);
      wait_done("t1", cyc);

      // 2: CMD8 with R7
      set_card(8, 40'h01000001AA, 5);
      expect_frame(6'd8, 32'h000001AA, 8'h87, 6);
      expect_res(40'h01000001AA, 1'b0);
      start(6'd8, 32'h000001AA, 3'd5);
      wait_done("t2", cyc);

      // 3: CMD58, card silent -> timeout after NCR_MAX polls
      set_card(0, 40'h0, 0);
      expect_frame(6'd58, 32'h0, 8'hFD, 8);
      expect_res(40'h0, 1'b1);
      rises0 = mon_rises;
      start(6'd58, 32'h0, 3'd5);
      wait_done("t3", cyc);
      check("t3_sclk_rises", 64'(mon_rises - rises0), 64'd128);
      check("t3_frame_cycles", 64'(cyc >= 16 * 32 && cyc <= 16 * 32 + 80), 64'd1);

      // 4: second start while busy must be ignored
      set_card(8, 40'h01, 1);
      expect_frame(6'd0, 32'h0, 8'h95, 2);
      expect_res(40'h01, 1'b0);
      base = mon_nbytes;
      start(6'd0, 32'h0, 3'd1);
      wait_bytes(base + 3);
      start(6'd8, 32'h000001AA, 3'd5);
      wait_done("t4", cyc);

      // 5: reset during WAIT_R, then CMD55
      set_card(0, 40'h0, 0);
      expect_frame(6'd58, 32'h0, 8'hFD, 8);
      expect_res(40'h0, 1'b1);
      base = mon_nbytes;
      start(6'd58, 32'h0, 3'd5);
      wait_bytes(base + 8);
      @(negedge clk_50);
      #2;
      reset_n = 1'b0;
      #1;
      check("t5_rst_cs_n", 64'(spi_cs_n), 64'd1);
      check("t5_rst_sclk", 64'(spi_sclk), 64'd0);
      check("t5_rst_busy", 64'(busy), 64'd0);
      check("t5_rst_mosi", 64'(spi_mosi), 64'd1);
      exp_mosi.delete();
      exp_res.delete();
      repeat (2) @(negedge clk_50);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_50);
      set_card(7, 40'h01, 1);
      expect_frame(6'd55, 32'h0, 8'h65, 1);
      expect_res(40'h01, 1'b0);
      start(6'd55, 32'h0, 3'd1);
      wait_done("t5", cyc);

      // 6: resp_len 0 behaves as R1, resp_len 7 as R7
      set_card(8, 40'h01, 1);
      expect_frame(6'd0, 32'h0, 8'h95, 2);
      expect_res(40'h01, 1'b0);
      start(6'd0, 32'h0, 3'd0);
      wait_done("t6a", cyc);

      set_card(8, 40'h01000001AA, 5);
      expect_frame(6'd8, 32'h000001AA, 8'h87, 6);
      expect_res(40'h01000001AA, 1'b0);
      start(6'd8, 32'h000001AA, 3'd7);
      wait_done("t6b", cyc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
